// File: rtl/synth_pkg.sv
// Shared types and field positions for the polyphonic voice allocator.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        APPLY
    } alloc_state_e;

    typedef struct packed {
        logic       note_on;
        logic [6:0] note;
        logic [7:0] velocity;
    } note_event_t;

    // Layout of a slot's packed word {gate, note, volume}
    localparam int NV_GATE_BIT = 15;
    localparam int NV_NOTE_MSB = 14;
    localparam int NV_NOTE_LSB = 8;
    localparam int NV_VOL_W    = 8;

    // A note-on with zero velocity is a note-off in disguise
    function automatic logic is_note_on(input note_event_t ev);
        return ev.note_on && (ev.velocity != '0);
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice slot: holds gate, note, volume and a saturating age counter.
module voice_slot
    import synth_pkg::*;
#(
    parameter int AGE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_on,
    input  logic                load_off,
    input  logic                age_inc,
    input  logic                clr_all,
    input  logic [6:0]          ld_note,
    input  logic [NV_VOL_W-1:0] ld_vel,
    output logic                gate,
    output logic [6:0]          note,
    output logic [AGE_W-1:0]    age,
    output logic [15:0]         nv
);

    logic [NV_VOL_W-1:0] volume;

    // Age increment that sticks at all-ones instead of wrapping
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == '1) ? a : a + AGE_W'(1);
    endfunction

    // Slot register update; panic clear outranks any load from the allocator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate   <= 1'b0;
            note   <= '0;
            volume <= '0;
            age    <= '0;
        end else if (clr_all) begin
            gate   <= 1'b0;
            volume <= '0;
            age    <= '0;
        end else if (load_on) begin
            gate   <= 1'b1;
            note   <= ld_note;
            volume <= ld_vel;
            age    <= '0;
        end else if (load_off) begin
            gate   <= 1'b0;
            note   <= ld_note;
            volume <= '0;
            age    <= '0;
        end else if (age_inc && gate) begin
            age    <= age_sat_inc(age);
        end
    end

    assign nv[NV_GATE_BIT]             = gate;
    assign nv[NV_NOTE_MSB:NV_NOTE_LSB] = note;
    assign nv[NV_VOL_W-1:0]            = volume;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans the slots one per clock for a matching
// note, the lowest free slot and the oldest gated slot, then applies a
// single update (retrigger, fill, steal or release).
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_note_on,
    input  logic [6:0]              ev_note,
    input  logic [7:0]              ev_velocity,
    input  logic                    all_off,
    output logic [16*NUM_VOICES-1:0] voice_nv,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic                    busy
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_e     state;
    note_event_t      ev_q;
    logic [IDX_W-1:0] scan_idx;

    logic             match_found;
    logic [IDX_W-1:0] match_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             old_found;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;

    logic [NUM_VOICES-1:0] slot_gate;
    logic [6:0]            slot_note [NUM_VOICES];
    logic [AGE_W-1:0]      slot_age  [NUM_VOICES];

    logic [NUM_VOICES-1:0] load_on;
    logic [NUM_VOICES-1:0] load_off;
    logic [NUM_VOICES-1:0] age_inc;
    logic [IDX_W-1:0]      target;

    logic             cur_gate;
    logic [6:0]       cur_note;
    logic [AGE_W-1:0] cur_age;

    assign ev_ready   = (state == IDLE) && !all_off;
    assign busy       = (state != IDLE);
    assign voice_gate = slot_gate;

    assign cur_gate = slot_gate[scan_idx];
    assign cur_note = slot_note[scan_idx];
    assign cur_age  = slot_age[scan_idx];

    // Event handshake, slot scan and candidate capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ev_q        <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_found   <= 1'b0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (all_off) begin
            state    <= IDLE;
            scan_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_valid && ev_ready) begin
                        ev_q        <= '{note_on: ev_note_on, note: ev_note, velocity: ev_velocity};
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        old_age     <= '0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match_found && cur_gate && (cur_note == ev_q.note)) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!free_found && !cur_gate) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strictly greater keeps the lowest index on an age tie
                    if (cur_gate && (!old_found || (cur_age > old_age))) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                        old_age   <= cur_age;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= APPLY;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                APPLY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decode the single update performed in APPLY into per-slot strobes
    always_comb begin
        load_on  = '0;
        load_off = '0;
        age_inc  = '0;
        target   = match_found ? match_idx : (free_found ? free_idx : old_idx);
        if (state == APPLY && !all_off) begin
            if (is_note_on(ev_q)) begin
                load_on[target] = 1'b1;
                age_inc         = '1;
                age_inc[target] = 1'b0;
            end else if (match_found) begin
                load_off[match_idx] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_slot
        voice_slot #(
            .AGE_W (AGE_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load_on  (load_on[k]),
            .load_off (load_off[k]),
            .age_inc  (age_inc[k]),
            .clr_all  (all_off),
            .ld_note  (ev_q.note),
            .ld_vel   (ev_q.velocity),
            .gate     (slot_gate[k]),
            .note     (slot_note[k]),
            .age      (slot_age[k]),
            .nv       (voice_nv[16*k +: 16])
        );
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator with NUM_VOICES = 4.
module tb_voice_allocator;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_note_on = 1'b0;
    logic [6:0]    ev_note = '0;
    logic [7:0]    ev_velocity = '0;
    logic          all_off = 1'b0;
    logic [63:0]   voice_nv;
    logic [3:0]    voice_gate;
    logic          busy;

    int errors = 0;
    int checks = 0;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_note_on  (ev_note_on),
        .ev_note     (ev_note),
        .ev_velocity (ev_velocity),
        .all_off     (all_off),
        .voice_nv    (voice_nv),
        .voice_gate  (voice_gate),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        on;
        logic [6:0]  note;
        logic [7:0]  vel;
        logic [63:0] exp_nv;
        logic [3:0]  exp_gate;
    } vec_t;

    typedef struct {
        logic       on;
        logic [6:0] note;
        logic [7:0] vel;
    } ev_t;

    vec_t vecs [11];
    ev_t  b2b  [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one event, wait for acceptance, then wait for the update to land
    task automatic send_event(input logic on, input logic [6:0] note, input logic [7:0] vel,
                              output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ev_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ev_ready) check("ready_timeout", 64'(ev_ready), 64'd1);
        ev_note_on  = on;
        ev_note     = note;
        ev_velocity = vel;
        ev_valid    = 1'b1;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        lat = 0;
        while (busy && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int k;
        int last;
        int cyc;
        logic rdy;

        vecs[0]  = '{1'b1, 7'd60, 8'd100, 64'h0000_0000_0000_BC64, 4'b0001};
        vecs[1]  = '{1'b1, 7'd60, 8'd20,  64'h0000_0000_0000_BC14, 4'b0001};
        vecs[2]  = '{1'b1, 7'd62, 8'd80,  64'h0000_0000_BE50_BC14, 4'b0011};
        vecs[3]  = '{1'b0, 7'd62, 8'd0,   64'h0000_0000_3E00_BC14, 4'b0001};
        vecs[4]  = '{1'b0, 7'd70, 8'd0,   64'h0000_0000_3E00_BC14, 4'b0001};
        vecs[5]  = '{1'b1, 7'd72, 8'd0,   64'h0000_0000_3E00_BC14, 4'b0001};
        vecs[6]  = '{1'b1, 7'd62, 8'd80,  64'h0000_0000_BE50_BC14, 4'b0011};
        vecs[7]  = '{1'b1, 7'd64, 8'd80,  64'h0000_C050_BE50_BC14, 4'b0111};
        vecs[8]  = '{1'b1, 7'd65, 8'd80,  64'hC150_C050_BE50_BC14, 4'b1111};
        vecs[9]  = '{1'b1, 7'd67, 8'd80,  64'hC150_C050_BE50_C350, 4'b1111};
        vecs[10] = '{1'b1, 7'd69, 8'd80,  64'hC150_C050_C550_C350, 4'b1111};

        b2b[0] = '{1'b1, 7'd40, 8'd10};
        b2b[1] = '{1'b1, 7'd41, 8'd10};
        b2b[2] = '{1'b1, 7'd42, 8'd10};
        b2b[3] = '{1'b1, 7'd43, 8'd10};
        b2b[4] = '{1'b0, 7'd41, 8'd0};
        b2b[5] = '{1'b1, 7'd44, 8'd10};

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("reset_nv", voice_nv, 64'h0);
        check("reset_gate", 64'(voice_gate), 64'h0);
        check("reset_ready", 64'(ev_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Table: fill, retrigger, release, ignored release, steal oldest
        for (int i = 0; i < 11; i++) begin
            send_event(vecs[i].on, vecs[i].note, vecs[i].vel, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NV + 1));
            check($sformatf("vec%0d_nv", i), voice_nv, vecs[i].exp_nv);
            check($sformatf("vec%0d_gate", i), 64'(voice_gate), 64'(vecs[i].exp_gate));
            check($sformatf("vec%0d_ready", i), 64'(ev_ready), 64'd1);
        end

        // Panic in IDLE: gates/volumes clear, notes kept
        @(negedge clk) all_off = 1'b1;
        #1 check("alloff_ready_low", 64'(ev_ready), 64'd0);
        @(negedge clk) all_off = 1'b0;
        check("alloff_idle_nv", voice_nv, 64'h4100_4000_4500_4300);

        // Back-to-back events with ev_valid held high
        k = 0;
        last = -1;
        cyc = 0;
        while (k < 6 && cyc < 200) begin
            @(negedge clk);
            rdy = ev_ready;
            if (rdy) begin
                ev_note_on  = b2b[k].on;
                ev_note     = b2b[k].note;
                ev_velocity = b2b[k].vel;
            end else begin
                ev_note_on  = 1'b1;
                ev_note     = 7'd99;
                ev_velocity = 8'd1;
            end
            ev_valid = 1'b1;
            @(posedge clk);
            cyc++;
            if (rdy) begin
                if (last >= 0) check($sformatf("b2b_interval%0d", k), 64'(cyc - last), 64'(NV + 2));
                last = cyc;
                k++;
            end
        end
        @(negedge clk) ev_valid = 1'b0;
        check("b2b_accepted", 64'(k), 64'd6);
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_done", 64'(busy), 64'd0);
        check("b2b_nv", voice_nv, 64'hAB0A_AA0A_AC0A_A80A);
        check("b2b_gate", 64'(voice_gate), 64'hF);

        // all_off during SCAN drops the event
        @(negedge clk);
        ev_note_on = 1'b1; ev_note = 7'd50; ev_velocity = 8'd90; ev_valid = 1'b1;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        check("scan_busy", 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk) all_off = 1'b1;
        #1 check("scan_alloff_ready", 64'(ev_ready), 64'd0);
        @(posedge clk);
        #1;
        check("scan_alloff_gate", 64'(voice_gate), 64'h0);
        check("scan_alloff_busy", 64'(busy), 64'd0);
        check("scan_alloff_nv", voice_nv, 64'h2B00_2A00_2C00_2800);
        @(negedge clk) all_off = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("scan_dropped_nv", voice_nv, 64'h2B00_2A00_2C00_2800);
        check("scan_dropped_ready", 64'(ev_ready), 64'd1);

        // Reset during APPLY loses the event
        @(negedge clk);
        ev_note_on = 1'b1; ev_note = 7'd50; ev_velocity = 8'd90; ev_valid = 1'b1;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (NV) @(posedge clk);
        #1 check("apply_busy", 64'(busy), 64'd1);
        @(negedge clk) reset = 1'b1;
        #1;
        check("apply_reset_nv", voice_nv, 64'h0);
        check("apply_reset_gate", 64'(voice_gate), 64'h0);
        check("apply_reset_ready", 64'(ev_ready), 64'd1);
        check("apply_reset_busy", 64'(busy), 64'd0);
        @(negedge clk) reset = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("apply_reset_hold_nv", voice_nv, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
